// File: rtl/ega_blit_master.sv
// EGA latch-copy blitter: programs write mode 1, then reads each source byte into the
// plane latches and writes it back at the destination, finally restoring Graphics reg 5.
module ega_blit_master #(
    parameter logic [19:0] BASE    = 20'hA0000,
    parameter int          STRIDE  = 40,
    parameter int          TIMEOUT = 15
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [13:0] iSrc,
    input  logic [13:0] iDst,
    input  logic [5:0]  iWidth,
    input  logic [8:0]  iHeight,
    input  logic [7:0]  iRestoreMode,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic        oBusReq,
    input  logic        iBusGnt,
    output logic [19:0] oAddr,
    output logic [7:0]  oWrData,
    output logic        oWrMem,
    output logic        oRdMem,
    output logic        oWrIo,
    input  logic [7:0]  iRdData,
    input  logic        iSel
);

    localparam int              WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [13:0]     STRIDE_OFS = 14'(STRIDE);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_MODE_IDX, S_MODE_DAT, S_RD_SETUP, S_RD_STROBE, S_RD_WAIT,
        S_ABORT, S_WR_STROBE, S_WR_HOLD1, S_WR_HOLD2, S_NEXT, S_RESTORE_IDX,
        S_RESTORE_DAT, S_DONE
    } state_t;

    state_t              state_r, nextState_s;
    logic [13:0]         src_r, dst_r, rowSrc_r, rowDst_r;
    logic [13:0]         srcNext_s, dstNext_s, rowSrcNext_s, rowDstNext_s;
    logic [5:0]          col_r, colNext_s, width_r, widthNext_s;
    logic [8:0]          row_r, rowNext_s, height_r, heightNext_s;
    logic [7:0]          restore_r, restoreNext_s;
    logic                modeDone_r, modeDoneNext_s, errored_r, erroredNext_s;
    logic [WAIT_W-1:0]   waitCnt_r, waitCntNext_s;
    logic                busy_r, done_r, error_r, busReq_r, wrMem_r, rdMem_r, wrIo_r;
    logic                busy_s, done_s, error_s, busReq_s, wrMem_s, rdMem_s, wrIo_s;
    logic [19:0]         addr_r, addr_s;
    logic [7:0]          wrData_r, wrData_s, rdCapture_r;
    logic                unusedRdCapture_s;

    assign unusedRdCapture_s = ^rdCapture_r;

    // Next-state, sequencing counters and the output values belonging to the next state.
    always_comb begin
        nextState_s    = state_r;
        srcNext_s      = src_r;
        dstNext_s      = dst_r;
        rowSrcNext_s   = rowSrc_r;
        rowDstNext_s   = rowDst_r;
        colNext_s      = col_r;
        rowNext_s      = row_r;
        widthNext_s    = width_r;
        heightNext_s   = height_r;
        restoreNext_s  = restore_r;
        modeDoneNext_s = modeDone_r;
        erroredNext_s  = errored_r;
        waitCntNext_s  = waitCnt_r;
        case (state_r)
            S_IDLE: begin
                if (iStart) begin
                    srcNext_s      = iSrc;
                    dstNext_s      = iDst;
                    rowSrcNext_s   = iSrc;
                    rowDstNext_s   = iDst;
                    widthNext_s    = iWidth;
                    heightNext_s   = iHeight;
                    restoreNext_s  = iRestoreMode;
                    colNext_s      = 6'd0;
                    rowNext_s      = 9'd0;
                    modeDoneNext_s = 1'b0;
                    erroredNext_s  = 1'b0;
                    if ((iWidth == 6'd0) || (iHeight == 9'd0)) begin
                        nextState_s = S_DONE;
                    end else begin
                        nextState_s = S_REQ;
                    end
                end else begin
                    nextState_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (iBusGnt) begin
                    nextState_s = modeDone_r ? S_RD_SETUP : S_MODE_IDX;
                end else begin
                    nextState_s = S_REQ;
                end
            end
            S_MODE_IDX: nextState_s = S_MODE_DAT;
            S_MODE_DAT: begin
                modeDoneNext_s = 1'b1;
                nextState_s    = S_RD_SETUP;
            end
            S_RD_SETUP: nextState_s = S_RD_STROBE;
            S_RD_STROBE: begin
                waitCntNext_s = WAIT_W'(1);
                nextState_s   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (iSel) begin
                    nextState_s = S_WR_STROBE;
                end else if (waitCnt_r == WAIT_LAST) begin
                    erroredNext_s = 1'b1;
                    nextState_s   = S_ABORT;
                end else begin
                    waitCntNext_s = waitCnt_r + WAIT_W'(1);
                end
            end
            S_ABORT:     nextState_s = S_RESTORE_IDX;
            S_WR_STROBE: nextState_s = S_WR_HOLD1;
            S_WR_HOLD1:  nextState_s = S_WR_HOLD2;
            S_WR_HOLD2:  nextState_s = S_NEXT;
            S_NEXT: begin
                // Row wrap reloads from the saved row start so offsets step by exactly STRIDE.
                if (col_r == (width_r - 6'd1)) begin
                    colNext_s = 6'd0;
                    if (row_r == (height_r - 9'd1)) begin
                        nextState_s = S_RESTORE_IDX;
                    end else begin
                        rowNext_s    = row_r + 9'd1;
                        rowSrcNext_s = rowSrc_r + STRIDE_OFS;
                        rowDstNext_s = rowDst_r + STRIDE_OFS;
                        srcNext_s    = rowSrc_r + STRIDE_OFS;
                        dstNext_s    = rowDst_r + STRIDE_OFS;
                        nextState_s  = iBusGnt ? S_RD_SETUP : S_REQ;
                    end
                end else begin
                    colNext_s   = col_r + 6'd1;
                    srcNext_s   = src_r + 14'd1;
                    dstNext_s   = dst_r + 14'd1;
                    nextState_s = iBusGnt ? S_RD_SETUP : S_REQ;
                end
            end
            S_RESTORE_IDX: nextState_s = S_RESTORE_DAT;
            S_RESTORE_DAT: nextState_s = S_DONE;
            S_DONE:        nextState_s = S_IDLE;
            default:       nextState_s = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state so every output leaves a flop.
    always_comb begin
        busy_s   = 1'b1;
        busReq_s = 1'b1;
        done_s   = 1'b0;
        error_s  = 1'b0;
        addr_s   = 20'h00000;
        wrData_s = 8'h00;
        wrMem_s  = 1'b0;
        rdMem_s  = 1'b0;
        wrIo_s   = 1'b0;
        case (nextState_s)
            S_IDLE: begin
                busy_s   = 1'b0;
                busReq_s = 1'b0;
            end
            S_MODE_IDX, S_RESTORE_IDX: begin
                addr_s   = 20'h003CE;
                wrData_s = 8'h05;
                wrIo_s   = 1'b1;
            end
            S_MODE_DAT: begin
                addr_s   = 20'h003CF;
                wrData_s = 8'h01;
                wrIo_s   = 1'b1;
            end
            S_RESTORE_DAT: begin
                addr_s   = 20'h003CF;
                wrData_s = restoreNext_s;
                wrIo_s   = 1'b1;
            end
            S_RD_SETUP, S_RD_WAIT: addr_s = BASE + {6'b000000, srcNext_s};
            S_RD_STROBE: begin
                addr_s  = BASE + {6'b000000, srcNext_s};
                rdMem_s = 1'b1;
            end
            S_WR_STROBE: begin
                addr_s  = BASE + {6'b000000, dstNext_s};
                wrMem_s = 1'b1;
            end
            S_WR_HOLD1, S_WR_HOLD2: addr_s = BASE + {6'b000000, dstNext_s};
            S_ABORT: begin
                done_s  = 1'b1;
                error_s = 1'b1;
            end
            S_DONE: begin
                busReq_s = 1'b0;
                done_s   = ~erroredNext_s;
            end
            default: addr_s = 20'h00000;
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r     <= S_IDLE;
            src_r       <= 14'd0;
            dst_r       <= 14'd0;
            rowSrc_r    <= 14'd0;
            rowDst_r    <= 14'd0;
            col_r       <= 6'd0;
            row_r       <= 9'd0;
            width_r     <= 6'd0;
            height_r    <= 9'd0;
            restore_r   <= 8'h00;
            modeDone_r  <= 1'b0;
            errored_r   <= 1'b0;
            waitCnt_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            busReq_r    <= 1'b0;
            addr_r      <= 20'h00000;
            wrData_r    <= 8'h00;
            wrMem_r     <= 1'b0;
            rdMem_r     <= 1'b0;
            wrIo_r      <= 1'b0;
            rdCapture_r <= 8'h00;
        end else begin
            state_r     <= nextState_s;
            src_r       <= srcNext_s;
            dst_r       <= dstNext_s;
            rowSrc_r    <= rowSrcNext_s;
            rowDst_r    <= rowDstNext_s;
            col_r       <= colNext_s;
            row_r       <= rowNext_s;
            width_r     <= widthNext_s;
            height_r    <= heightNext_s;
            restore_r   <= restoreNext_s;
            modeDone_r  <= modeDoneNext_s;
            errored_r   <= erroredNext_s;
            waitCnt_r   <= waitCntNext_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            busReq_r    <= busReq_s;
            addr_r      <= addr_s;
            wrData_r    <= wrData_s;
            wrMem_r     <= wrMem_s;
            rdMem_r     <= rdMem_s;
            wrIo_r      <= wrIo_s;
            rdCapture_r <= (iSel && (state_r == S_RD_WAIT)) ? iRdData : rdCapture_r;
        end
    end

    // Reset must silence the bus within the very cycle it is asserted.
    assign oBusy   = busy_r   & ~iRst;
    assign oDone   = done_r   & ~iRst;
    assign oError  = error_r  & ~iRst;
    assign oBusReq = busReq_r & ~iRst;
    assign oWrMem  = wrMem_r  & ~iRst;
    assign oRdMem  = rdMem_r  & ~iRst;
    assign oWrIo   = wrIo_r   & ~iRst;
    assign oAddr   = iRst ? 20'h00000 : addr_r;
    assign oWrData = iRst ? 8'h00 : wrData_r;

endmodule

// File: tb/tb_ega_blit_master.sv
// Directed bench: a transaction-level model lists the bus strobes each blit must produce,
// and a per-cycle monitor checks the DUT bus against that list and the hold/setup rules.
module tb_ega_blit_master;
    localparam logic [19:0] BASE    = 20'hA0000;
    localparam int          STRIDE  = 40;
    localparam int          TIMEOUT = 15;

    typedef struct {
        int          kind;   // 0 read, 1 mem write, 2 io write
        logic [19:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        iClk, iRst, iStart, iBusGnt, iSel;
    logic [13:0] iSrc, iDst;
    logic [5:0]  iWidth;
    logic [8:0]  iHeight;
    logic [7:0]  iRestoreMode, iRdData, oWrData;
    logic        oBusy, oDone, oError, oBusReq, oWrMem, oRdMem, oWrIo;
    logic [19:0] oAddr;

    ega_blit_master #(.BASE(BASE), .STRIDE(STRIDE), .TIMEOUT(TIMEOUT)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSrc(iSrc), .iDst(iDst),
        .iWidth(iWidth), .iHeight(iHeight), .iRestoreMode(iRestoreMode),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oBusReq(oBusReq),
        .iBusGnt(iBusGnt), .oAddr(oAddr), .oWrData(oWrData), .oWrMem(oWrMem),
        .oRdMem(oRdMem), .oWrIo(oWrIo), .iRdData(iRdData), .iSel(iSel)
    );

    int checks = 0;
    int failures = 0;
    ev_t expq[$];
    logic [19:0] rdLog[$];
    logic [19:0] wrLog[$];
    int rdCycLog[$];
    int cyc = 0, doneCount = 0, errCount = 0, doneCyc = -1, errCyc = -1, strobeCount = 0;
    bit busReqSeen = 0, respond = 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [19:0] memAddr(input int off);
        return BASE + 20'(off % 16384);
    endfunction

    task automatic pushEv(input int kind, input logic [19:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        expq.push_back(e);
    endtask

    // Expected bus transactions of a complete blit; timeout blits stop after the first read.
    task automatic model(input int src, input int dst, input int w, input int h,
                         input logic [7:0] rm, input bit timeout);
        if (w == 0 || h == 0) return;
        pushEv(2, 20'h003CE, 8'h05);
        pushEv(2, 20'h003CF, 8'h01);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (!(timeout && (r != 0 || c != 0))) pushEv(0, memAddr(src + r * STRIDE + c), 8'h00);
                if (!timeout) pushEv(1, memAddr(dst + r * STRIDE + c), 8'h00);
            end
        end
        pushEv(2, 20'h003CE, 8'h05);
        pushEv(2, 20'h003CF, rm);
    endtask

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Responder: read data valid the cycle after each read strobe.
    initial begin
        bit pend;
        pend = 1'b0;
        iSel = 1'b0;
        forever begin
            @(negedge iClk);
            iSel = pend & respond;
            pend = oRdMem;
        end
    end

    // Per-cycle monitor against the expected transaction list.
    initial begin
        logic [19:0] prevAddr, holdAddr;
        bit prevStrobe;
        int holdCnt;
        prevAddr = 20'h0; holdAddr = 20'h0; prevStrobe = 1'b0; holdCnt = 0;
        forever begin
            int n;
            @(posedge iClk);
            #2;
            cyc++;
            n = int'(oWrMem) + int'(oRdMem) + int'(oWrIo);
            if (n > 1) check(1'b0, "one_strobe", n, 1);
            if (!oWrIo && oWrData != 8'h00) check(1'b0, "wrdata_idle", oWrData, 0);
            if (holdCnt > 0) begin
                check(oAddr == holdAddr && n == 0, "wr_hold", oAddr, holdAddr);
                holdCnt--;
            end
            if (oRdMem) begin
                check(oAddr == prevAddr && !prevStrobe, "rd_setup", prevAddr, oAddr);
                rdLog.push_back(oAddr);
                rdCycLog.push_back(cyc);
            end
            if (oWrMem) begin
                holdCnt = 2;
                holdAddr = oAddr;
                wrLog.push_back(oAddr);
            end
            if (n != 0) begin
                strobeCount++;
                check(oBusReq, "strobe_busreq", oBusReq, 1);
                if (expq.size() == 0) begin
                    check(1'b0, "unexpected_strobe", oAddr, 0);
                end else begin
                    ev_t e;
                    int k;
                    e = expq.pop_front();
                    k = oRdMem ? 0 : (oWrMem ? 1 : 2);
                    check(k == e.kind, "ev_kind", k, e.kind);
                    check(oAddr == e.addr, "ev_addr", oAddr, e.addr);
                    if (k == 2) check(oWrData == e.data, "ev_data", oWrData, e.data);
                end
            end
            if (oDone) begin doneCount++; doneCyc = cyc; end
            if (oError) begin errCount++; errCyc = cyc; end
            if (oBusReq) busReqSeen = 1'b1;
            prevAddr = oAddr;
            prevStrobe = (n != 0);
        end
    end

    task automatic startBlit(input logic [13:0] s, input logic [13:0] d, input logic [5:0] w,
                             input logic [8:0] h, input logic [7:0] rm);
        @(negedge iClk);
        iSrc = s; iDst = d; iWidth = w; iHeight = h; iRestoreMode = rm; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (oBusy && n < budget) begin
            @(negedge iClk);
            n++;
        end
        check(!oBusy, "idle_timeout", oBusy, 0);
        @(negedge iClk);
        check(expq.size() == 0, "events_left", expq.size(), 0);
    endtask

    task automatic clearLogs();
        rdLog.delete(); wrLog.delete(); rdCycLog.delete();
        doneCount = 0; errCount = 0; doneCyc = -1; errCyc = -1; busReqSeen = 1'b0;
    endtask

    initial begin
        logic [19:0] rdExp[6];
        logic [19:0] wrExp[6];
        int sc0, n;
        iRst = 1'b1; iStart = 1'b0; iBusGnt = 1'b1; iRdData = 8'h3C;
        iSrc = 14'h0; iDst = 14'h0; iWidth = 6'd0; iHeight = 9'd0; iRestoreMode = 8'h00;
        repeat (3) @(negedge iClk);
        check(!oBusy && !oDone && !oError && !oBusReq, "reset_ctl", {oBusy, oDone, oError, oBusReq}, 0);
        check(oAddr == 20'h0 && !oWrMem && !oRdMem && !oWrIo, "reset_bus", oAddr, 0);
        iRst = 1'b0;
        @(negedge iClk);

        // Single byte copy
        clearLogs();
        model(0, 40, 1, 1, 8'h00, 1'b0);
        check(expq.size() == 6, "model_len1", expq.size(), 6);
        startBlit(14'h0000, 14'h0028, 6'd1, 9'd1, 8'h00);
        waitIdle(100);
        check(doneCount == 1 && errCount == 0, "single_done", {doneCount[15:0], errCount[15:0]}, 32'h00010000);
        check(wrLog.size() == 1 && wrLog[0] == 20'hA0028, "single_wr", wrLog.size() ? wrLog[0] : 0, 20'hA0028);

        // 3x2 rectangle with row stride
        clearLogs();
        rdExp = '{20'hA0010, 20'hA0011, 20'hA0012, 20'hA0038, 20'hA0039, 20'hA003A};
        wrExp = '{20'hA0100, 20'hA0101, 20'hA0102, 20'hA0128, 20'hA0129, 20'hA012A};
        model(16'h0010, 16'h0100, 3, 2, 8'h10, 1'b0);
        startBlit(14'h0010, 14'h0100, 6'd3, 9'd2, 8'h10);
        waitIdle(200);
        check(rdLog.size() == 6 && wrLog.size() == 6, "rect_count", rdLog.size(), 6);
        for (int i = 0; i < 6 && i < rdLog.size() && i < wrLog.size(); i++) begin
            check(rdLog[i] == rdExp[i], "rect_rd", rdLog[i], rdExp[i]);
            check(wrLog[i] == wrExp[i], "rect_wr", wrLog[i], wrExp[i]);
        end
        if (rdCycLog.size() >= 2) check(rdCycLog[1] - rdCycLog[0] == 7, "byte_period", rdCycLog[1] - rdCycLog[0], 7);
        check(doneCount == 1, "rect_done", doneCount, 1);

        // 14-bit offset wrap
        clearLogs();
        model(16'h3FFF, 16'h0200, 2, 1, 8'h02, 1'b0);
        startBlit(14'h3FFF, 14'h0200, 6'd2, 9'd1, 8'h02);
        waitIdle(100);
        check(rdLog.size() == 2 && rdLog[0] == 20'hA3FFF, "wrap_rd0", rdLog.size() ? rdLog[0] : 0, 20'hA3FFF);
        check(rdLog.size() == 2 && rdLog[1] == 20'hA0000, "wrap_rd1", rdLog.size() > 1 ? rdLog[1] : 0, 20'hA0000);

        // Read timeout
        clearLogs();
        respond = 1'b0;
        model(16'h0005, 16'h0300, 1, 1, 8'h5A, 1'b1);
        startBlit(14'h0005, 14'h0300, 6'd1, 9'd1, 8'h5A);
        waitIdle(100);
        respond = 1'b1;
        check(errCount == 1 && doneCount == 1, "to_pulses", {errCount[15:0], doneCount[15:0]}, 32'h00010001);
        check(errCyc == doneCyc, "to_same_cycle", errCyc, doneCyc);
        if (rdCycLog.size() > 0) check(errCyc - rdCycLog[0] == TIMEOUT, "to_latency", errCyc - rdCycLog[0], TIMEOUT);
        check(wrLog.size() == 0, "to_no_write", wrLog.size(), 0);

        // Grant loss during the first byte's write hold, plus a start while busy
        clearLogs();
        model(16'h0100, 16'h0300, 2, 1, 8'h03, 1'b0);
        startBlit(14'h0100, 14'h0300, 6'd2, 9'd1, 8'h03);
        n = 0;
        while (!oWrMem && n < 50) begin @(negedge iClk); n++; end
        check(oWrMem, "gnt_wait_wr", oWrMem, 1);
        @(negedge iClk);
        iBusGnt = 1'b0;
        sc0 = strobeCount;
        for (int i = 0; i < 6; i++) begin
            iStart = (i == 2);
            iSrc = 14'h1234; iWidth = 6'd5; iHeight = 9'd5;
            @(negedge iClk);
            check(oBusReq && oBusy, "pause_busreq", {oBusReq, oBusy}, 2'b11);
        end
        iStart = 1'b0;
        check(strobeCount == sc0, "pause_nostrobe", strobeCount, sc0);
        iBusGnt = 1'b1;
        waitIdle(100);
        check(doneCount == 1 && wrLog.size() == 2, "pause_done", {doneCount[15:0], wrLog.size()}, 32'h00010002);

        // Null blit
        clearLogs();
        @(negedge iClk);
        iSrc = 14'h0; iDst = 14'h0; iWidth = 6'd0; iHeight = 9'd5; iRestoreMode = 8'h00; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        check(oDone && oBusy, "null_done", {oDone, oBusy}, 2'b11);
        @(negedge iClk);
        check(!oBusy && !oDone, "null_idle", {oBusy, oDone}, 0);
        repeat (3) @(negedge iClk);
        check(!busReqSeen && doneCount == 1, "null_nobus", {busReqSeen, doneCount[15:0]}, 1);

        // Reset during read wait
        clearLogs();
        respond = 1'b0;
        model(16'h0000, 16'h0010, 2, 1, 8'h00, 1'b0);
        startBlit(14'h0000, 14'h0010, 6'd2, 9'd1, 8'h00);
        n = 0;
        while (!oRdMem && n < 50) begin @(negedge iClk); n++; end
        check(oRdMem, "rst_wait_rd", oRdMem, 1);
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        check(!oBusy && !oBusReq && !oRdMem && !oWrMem && !oWrIo, "rst_same_cycle",
              {oBusy, oBusReq, oRdMem, oWrMem, oWrIo}, 0);
        @(negedge iClk);
        iRst = 1'b0;
        expq.delete();
        respond = 1'b1;
        repeat (10) @(negedge iClk);
        check(doneCount == 0 && !oBusy, "rst_no_done", {doneCount[15:0], oBusy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
